coin_bank: RTL and testbench
============================

Name: coin_bank

Overview:
- Credit-keeping stage directly upstream of the vending dispenser.
- Debounces the nickel, dime and quarter inputs and accumulates credit in 5-cent units.
- Presents the credit as coinVal and enables the dispenser while credit exists.
- Consumes the dispenser's down_5/down_10/down_25 charge pulses, and pays out the remaining credit as change on a coin-return request.

Parameters:
- DEBOUNCE_CYCLES, 8, cycles a synchronized coin input must hold a new level before it is accepted.
- MAX_CREDIT, 63, saturation limit of credit in 5-cent units; must be ≤63.
- RETURN_TICKS, 4, cycles between successive change-coin pulses during payout.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- coin_5  input  1  raw nickel-slot level; asynchronous, bouncy.
- coin_10  input  1  raw dime-slot level.
- coin_25  input  1  raw quarter-slot level.
- coin_return  input  1  one-cycle synchronous request to refund all credit.
- down_5  input  1  one-cycle pulse from dispenser: subtract 1 unit.
- down_10  input  1  one-cycle pulse: subtract 2 units.
- down_25  input  1  one-cycle pulse: subtract 5 units.
- coinVal  output  6  current credit in 5-cent units.
- enable  output  1  dispenser enable.
- coin_reject  output  1  one-cycle pulse: accepted coin edge not credited.
- ret_5  output  1  one-cycle pulse: eject a nickel.
- ret_10  output  1  one-cycle pulse: eject a dime.
- ret_25  output  1  one-cycle pulse: eject a quarter.
- returning  output  1  high while in payout.

Behaviour:
- Reset (async, any time, including mid-payout):
  - credit=0, state IDLE, synchronizers/debounce counters/debounced levels=0, timer=0.
  - All outputs 0.
- Coin input path (one per slot):
  - 2-flop synchronizer.
  - Debounce counter clears whenever the synchronized level equals the debounced level; otherwise it increments. When it reaches DEBOUNCE_CYCLES-1, the debounced level toggles and the counter clears.
  - Debounced rising edge produces a one-cycle insert pulse. Falling edges produce nothing.
  - Latency from a clean raw rise to credit update: 2 + DEBOUNCE_CYCLES + 1 cycles.
- Per-cycle credit arithmetic, computed 8-bit:
  - add = 1·ins5 + 2·ins10 + 5·ins25.
  - sub = 1·down_5 + 2·down_10 + 5·down_25.
  - Simultaneous inserts and decrements in one cycle are all applied.
  - Decrement underflow: result clamps to 0. No flag.
  - Insert overflow: if credit − sub + add > MAX_CREDIT, coins are processed in order 25, 10, 5. Each coin that would exceed MAX_CREDIT is dropped and coin_reject pulses one cycle, once per cycle regardless of how many coins are dropped. Credit never exceeds MAX_CREDIT.
- State machine:
  - IDLE: credit=0. Any credited insert → CREDIT. coin_return ignored.
  - CREDIT: enable=1. Credit reaching 0 via decrements → IDLE. coin_return=1 → RETURN; the transition takes priority, and any same-cycle inserts and decrements are still applied first.
  - RETURN: enable=0, returning=1.
    - All coin insert pulses are rejected (coin_reject pulse); down_* ignored.
    - Timer counts 0..RETURN_TICKS-1. At terminal count, exactly one ret pulse is emitted, chosen as ret_25 if credit≥5, else ret_10 if credit≥2, else ret_5, and credit drops by 5/2/1 respectively.
    - When credit reaches 0 → IDLE the next cycle; returning drops with it.
    - The first ret pulse occurs RETURN_TICKS cycles after entry.
- Outputs:
  - coinVal = credit, registered.
  - enable = (state==CREDIT), registered, updates the same cycle as state.
  - The dispenser must see coinVal update no later than enable.

Test Plan:
1. Reset, then a clean 20-cycle coin_25 pulse → one coin credited: coinVal=5 exactly 11 cycles after the raw rise, enable=1, no reject.
2. coin_10 bouncing 3 times (2-cycle glitches) then held high → exactly one credit: coinVal=2. A glitch shorter than 8 cycles alone → coinVal unchanged.
3. Credit=60, insert a quarter → coin_reject one pulse, coinVal stays 60. Then insert a nickel → coinVal=61, no reject.
4. Credit=7, down_25 and down_10 in the same cycle as a debounced nickel insert → coinVal=1. Then down_10 alone → coinVal=0 (clamped), state IDLE, enable=0.
5. Credit=8, coin_return → returning=1, enable=0. Exactly one of each pulse at intervals of 4 cycles: ret_25, ret_10, ret_5. Then coinVal=0, IDLE. A quarter inserted during payout → coin_reject only.
6. Assert reset in the middle of scenario 5 payout → immediately coinVal=0, all ret_* 0, returning=0. After release, inserts credit normally.

Source files
------------

// File: rtl/coin_bank.sv
// coin_bank: credit keeper that sits directly upstream of the vending dispenser.
//   Each coin slot is synchronized and debounced. A debounced rising edge
//   adds credit in 5-cent units, saturating at MAX_CREDIT. The dispenser's
//   down_* pulses subtract credit. coin_return pays the remaining credit
//   back out as a timed train of change-coin pulses.
// Ports:
//   clk, reset                  clock; asynchronous active-high reset
//   coin_5/coin_10/coin_25      raw, bouncy slot levels
//   coin_return                 one-cycle refund request
//   down_5/down_10/down_25      dispenser charge pulses (1/2/5 units)
//   coinVal                     registered credit in 5-cent units
//   enable                      dispenser enable (state CREDIT)
//   coin_reject                 one-cycle pulse: accepted coin edge not credited
//   ret_5/ret_10/ret_25         one-cycle change-eject pulses
//   returning                   high while paying out

// Per-slot input path: 2-flop synchronizer, debouncer, rising-edge pulse.
module coin_debounce #(
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic ins
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES > 1 ? DEBOUNCE_CYCLES : 2);

  logic          s1, s2, deb;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      deb <= 1'b0;
      cnt <= '0;
      ins <= 1'b0;
    end else begin
      s1  <= raw;
      s2  <= s1;
      ins <= 1'b0;
      if (s2 == deb) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        deb <= ~deb;
        cnt <= '0;
        ins <= ~deb;  // only the 0->1 toggle produces an insert
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

module coin_bank #(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int MAX_CREDIT      = 63,
  parameter int RETURN_TICKS    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin_5,
  input  logic       coin_10,
  input  logic       coin_25,
  input  logic       coin_return,
  input  logic       down_5,
  input  logic       down_10,
  input  logic       down_25,
  output logic [5:0] coinVal,
  output logic       enable,
  output logic       coin_reject,
  output logic       ret_5,
  output logic       ret_10,
  output logic       ret_25,
  output logic       returning
);
  localparam int NUM_SLOTS = 3;
  localparam int TW        = $clog2(RETURN_TICKS > 1 ? RETURN_TICKS : 2);

  typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_RETURN} state_t;

  // Slot order everywhere: [0]=nickel, [1]=dime, [2]=quarter.
  logic [NUM_SLOTS-1:0] raw, ins;
  assign raw = {coin_25, coin_10, coin_5};

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb [NUM_SLOTS-1:0] (
    .clk   (clk),
    .reset (reset),
    .raw   (raw),
    .ins   (ins)
  );

  state_t        state, state_nxt;
  logic [5:0]    credit, credit_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic          rej_nxt;
  logic [2:0]    ret_nxt;  // {25,10,5}
  logic [7:0]    credit8, sub, acc;

  assign credit8 = {2'b00, credit};
  assign sub     = (down_5 ? 8'd1 : 8'd0) + (down_10 ? 8'd2 : 8'd0) + (down_25 ? 8'd5 : 8'd0);

  always_comb begin
    state_nxt  = state;
    credit_nxt = credit;
    timer_nxt  = '0;
    rej_nxt    = 1'b0;
    ret_nxt    = 3'b000;
    acc        = 8'd0;
    case (state)
      S_RETURN: begin
        rej_nxt = |ins;
        if (timer == TW'(RETURN_TICKS - 1)) begin
          if (credit >= 6'd5) begin
            ret_nxt    = 3'b100;
            credit_nxt = credit - 6'd5;
          end else if (credit >= 6'd2) begin
            ret_nxt    = 3'b010;
            credit_nxt = credit - 6'd2;
          end else if (credit != 6'd0) begin
            ret_nxt    = 3'b001;
            credit_nxt = credit - 6'd1;
          end
        end else begin
          timer_nxt = timer + TW'(1);
        end
        if (credit_nxt == 6'd0) state_nxt = S_IDLE;
      end
      default: begin
        // Charges first (clamped at 0), then coins largest-first; a coin
        // that would push past MAX_CREDIT is dropped and flagged.
        acc = (credit8 >= sub) ? credit8 - sub : 8'd0;
        if (ins[2]) begin
          if (acc + 8'd5 <= 8'(MAX_CREDIT)) acc = acc + 8'd5;
          else                              rej_nxt = 1'b1;
        end
        if (ins[1]) begin
          if (acc + 8'd2 <= 8'(MAX_CREDIT)) acc = acc + 8'd2;
          else                              rej_nxt = 1'b1;
        end
        if (ins[0]) begin
          if (acc + 8'd1 <= 8'(MAX_CREDIT)) acc = acc + 8'd1;
          else                              rej_nxt = 1'b1;
        end
        credit_nxt = acc[5:0];
        if (state == S_CREDIT) begin
          if (coin_return)       state_nxt = S_RETURN;
          else if (acc == 8'd0)  state_nxt = S_IDLE;
        end else if (acc != 8'd0) begin
          state_nxt = S_CREDIT;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      credit      <= '0;
      timer       <= '0;
      coin_reject <= 1'b0;
      ret_25      <= 1'b0;
      ret_10      <= 1'b0;
      ret_5       <= 1'b0;
    end else begin
      state       <= state_nxt;
      credit      <= credit_nxt;
      timer       <= timer_nxt;
      coin_reject <= rej_nxt;
      {ret_25, ret_10, ret_5} <= ret_nxt;
    end
  end

  // Credit and state share one edge, so coinVal is never behind enable.
  assign coinVal   = credit;
  assign enable    = (state == S_CREDIT);
  assign returning = (state == S_RETURN);
endmodule

// File: tb/tb_coin_bank.sv
// Self-checking bench for coin_bank: table of coin inserts with expected
// credit/reject, plus hand-written sequences for latency, same-cycle
// charges, payout timing (event scoreboard) and reset during payout.
module tb_coin_bank;
  logic       clk = 1'b0;
  logic       reset;
  logic       coin_5, coin_10, coin_25, coin_return;
  logic       down_5, down_10, down_25;
  logic [5:0] coinVal;
  logic       enable, coin_reject, ret_5, ret_10, ret_25, returning;

  coin_bank #(.DEBOUNCE_CYCLES(8), .MAX_CREDIT(63), .RETURN_TICKS(4)) dut (
    .clk(clk), .reset(reset),
    .coin_5(coin_5), .coin_10(coin_10), .coin_25(coin_25),
    .coin_return(coin_return),
    .down_5(down_5), .down_10(down_10), .down_25(down_25),
    .coinVal(coinVal), .enable(enable), .coin_reject(coin_reject),
    .ret_5(ret_5), .ret_10(ret_10), .ret_25(ret_25), .returning(returning)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int rej_seen = 0;

  typedef struct {
    int slot;      // 0 nickel, 1 dime, 2 quarter
    int bounces;   // 2-cycle glitches before the hold
    bit hold;      // follow glitches with a clean 20-cycle high
    int exp_val;
    int exp_rej;
  } vec_t;

  typedef struct {
    int cyc;       // cycles after coin_return was driven
    int code;      // {coin_reject, ret_25, ret_10, ret_5}
    int val;       // coinVal at that cycle
  } ev_t;

  vec_t tbl[$];
  ev_t  sb[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (coin_reject) rej_seen++;
  endtask

  task automatic set_coin(input int slot, input logic v);
    case (slot)
      0:       coin_5  = v;
      1:       coin_10 = v;
      default: coin_25 = v;
    endcase
  endtask

  task automatic insert(input int slot, input int bounces, input bit hold);
    for (int b = 0; b < bounces; b++) begin
      set_coin(slot, 1'b1); tick(); tick();
      set_coin(slot, 1'b0); tick(); tick();
    end
    if (hold) begin
      set_coin(slot, 1'b1);
      repeat (20) tick();
      set_coin(slot, 1'b0);
    end
    repeat (20) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    coin_5 = 0; coin_10 = 0; coin_25 = 0; coin_return = 0;
    down_5 = 0; down_10 = 0; down_25 = 0;
    tick(); tick();
    reset = 1'b0;
    rej_seen = 0;
  endtask

  task automatic build8();
    insert(2, 0, 1'b1);
    insert(1, 0, 1'b1);
    insert(0, 0, 1'b1);
    chk("build8_val", coinVal, 8);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int code;
    ev_t e;

    // ---- table fill: from 0 credit after reset ----
    tbl.push_back('{1, 3, 1'b1, 2, 0});   // bouncy dime -> one credit
    tbl.push_back('{0, 1, 1'b0, 2, 0});   // lone short glitch -> nothing
    for (int i = 0; i < 11; i++) tbl.push_back('{2, 0, 1'b1, 7 + 5*i, 0});
    for (int i = 0; i < 3; i++)  tbl.push_back('{0, 0, 1'b1, 58 + i, 0});
    tbl.push_back('{2, 0, 1'b1, 60, 1});  // quarter would overflow 63
    tbl.push_back('{0, 0, 1'b1, 61, 0});  // nickel still fits

    // ---- reset state ----
    do_reset();
    chk("rst_coinVal", coinVal, 0);
    chk("rst_enable", enable, 0);
    chk("rst_returning", returning, 0);
    chk("rst_ret", {ret_25, ret_10, ret_5}, 0);
    chk("rst_reject", coin_reject, 0);

    // ---- clean quarter: credit lands exactly 11 cycles after raw rise ----
    coin_25 = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == 10) chk("lat_early_val", coinVal, 0);
      if (k == 11) begin
        chk("lat_val", coinVal, 5);
        chk("lat_enable", enable, 1);
      end
    end
    repeat (9) tick();
    coin_25 = 1'b0;
    repeat (20) tick();
    chk("lat_reject", rej_seen, 0);
    chk("lat_final_val", coinVal, 5);

    // ---- table-driven inserts ----
    do_reset();
    foreach (tbl[i]) begin
      rej_seen = 0;
      insert(tbl[i].slot, tbl[i].bounces, tbl[i].hold);
      chk($sformatf("tbl%0d_val", i), coinVal, tbl[i].exp_val);
      chk($sformatf("tbl%0d_rej", i), rej_seen, tbl[i].exp_rej);
      chk($sformatf("tbl%0d_en", i), enable, tbl[i].exp_val != 0);
    end

    // ---- same-cycle charges with a nickel insert, then clamp to 0 ----
    do_reset();
    insert(2, 0, 1'b1);
    insert(1, 0, 1'b1);
    chk("sim_pre_val", coinVal, 7);
    rej_seen = 0;
    coin_5 = 1'b1;
    repeat (10) tick();
    down_25 = 1'b1; down_10 = 1'b1;   // insert pulse is live this cycle
    tick();
    down_25 = 1'b0; down_10 = 1'b0;
    chk("sim_val", coinVal, 1);
    chk("sim_enable", enable, 1);
    repeat (10) tick();
    coin_5 = 1'b0;
    repeat (20) tick();
    down_10 = 1'b1;
    tick();
    down_10 = 1'b0;
    chk("clamp_val", coinVal, 0);
    chk("clamp_enable", enable, 0);
    chk("clamp_reject", rej_seen, 0);
    tick();
    chk("clamp_idle_enable", enable, 0);

    // ---- payout of 8 units with a quarter inserted during payout ----
    do_reset();
    build8();
    sb.delete();
    sb.push_back('{5,  4'b0100, 3});
    sb.push_back('{9,  4'b0010, 1});
    sb.push_back('{11, 4'b1000, 1});
    sb.push_back('{13, 4'b0001, 0});
    coin_return = 1'b1;
    coin_25 = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 1) begin
        coin_return = 1'b0;
        chk("pay_returning", returning, 1);
        chk("pay_enable", enable, 0);
      end
      code = {coin_reject, ret_25, ret_10, ret_5};
      if (code != 0) begin
        if (sb.size() == 0) begin
          chk("pay_unexpected_event", code, 0);
        end else begin
          e = sb.pop_front();
          chk($sformatf("pay_ev%0d_cycle", e.code), c, e.cyc);
          chk($sformatf("pay_ev%0d_code", e.code), code, e.code);
          chk($sformatf("pay_ev%0d_val", e.code), coinVal, e.val);
        end
      end
    end
    chk("pay_missing_events", sb.size(), 0);
    chk("pay_end_val", coinVal, 0);
    chk("pay_end_returning", returning, 0);
    chk("pay_end_enable", enable, 0);
    coin_25 = 1'b0;
    repeat (20) tick();
    chk("pay_after_val", coinVal, 0);

    // ---- asynchronous reset in the middle of a payout ----
    do_reset();
    build8();
    coin_return = 1'b1;
    tick();
    coin_return = 1'b0;
    repeat (5) tick();              // first ret_25 has gone out
    chk("mid_val_before", coinVal, 3);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_val", coinVal, 0);
    chk("mid_rst_ret", {ret_25, ret_10, ret_5}, 0);
    chk("mid_rst_returning", returning, 0);
    chk("mid_rst_enable", enable, 0);
    tick();
    reset = 1'b0;
    rej_seen = 0;
    insert(2, 0, 1'b1);
    chk("post_rst_val", coinVal, 5);
    chk("post_rst_enable", enable, 1);
    chk("post_rst_reject", rej_seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
